// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_entry
//  Purpose  : 4x4 matrix-keypad controller. It scans the columns, debounces
//             presses and releases, decodes keys and drives an editable
//             numeric entry buffer with backspace (*) and commit (#).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DIGITS    : number of 4-bit digits held in the entry buffer (>=1)
//    SCAN_DIV  : clk cycles per scan tick (>=2)
//    DEBOUNCE  : consecutive identical ticks to accept a press/release (>=1)
//  Ports
//    clk       in   system clock
//    reset     in   asynchronous active-low reset
//    row       in   [3:0] keypad rows, active-low, asynchronous to clk
//    col       out  [3:0] column drive, one-hot active-low
//    hex_mode  in   1: keys A-D enter digits 10-13, 0: buffer ignores them
//    key_value out  [3:0] code of the last accepted key
//    key_valid out  one-cycle pulse per accepted press
//    entry     out  [DIGITS*4-1:0] live buffer, newest digit in [3:0]
//    count     out  digits currently held
//    full      out  count == DIGITS
//    out       out  [DIGITS*4-1:0] last committed value
//    enter     out  one-cycle pulse when out is updated
// ============================================================================
module keypad_entry #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   row,
    output logic [3:0]                   col,
    input  logic                         hex_mode,
    output logic [3:0]                   key_value,
    output logic                         key_valid,
    output logic [DIGITS*4-1:0]          entry,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         full,
    output logic [DIGITS*4-1:0]          out,
    output logic                         enter
);

    localparam int c_dw    = DIGITS * 4;
    localparam int c_cnt_w = $clog2(DIGITS + 1);
    localparam int c_div_w = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int c_deb_w = $clog2(DEBOUNCE + 1);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_deb_w-1:0] c_deb      = c_deb_w'(DEBOUNCE);
    localparam logic [c_deb_w-1:0] c_deb_one  = c_deb_w'(1);
    localparam logic [c_cnt_w-1:0] c_digits   = c_cnt_w'(DIGITS);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Key map lookup: row r / column c to key code (* = 14, # = 15).
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = 4'd10;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = 4'd11;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = 4'd12;
            4'b11_00: code = 4'd14;
            4'b11_01: code = 4'd0;
            4'b11_10: code = 4'd15;
            default:  code = 4'd13;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]         row_meta_q, row_meta_d;
    logic [3:0]         row_sync_q, row_sync_d;
    logic [c_div_w-1:0] div_q,      div_d;
    state_t             state_q,    state_d;
    logic [1:0]         col_idx_q,  col_idx_d;
    logic [1:0]         row_idx_q,  row_idx_d;
    logic [c_deb_w-1:0] deb_q,      deb_d;
    logic [3:0]         key_value_q, key_value_d;
    logic [c_dw-1:0]    entry_q,    entry_d;
    logic [c_cnt_w-1:0] count_q,    count_d;
    logic [c_dw-1:0]    out_q,      out_d;
    logic               enter_q,    enter_d;

    logic               w_tick;
    logic [3:0]         w_row_low;
    logic [1:0]         w_lowest;
    logic               w_press;
    logic [1:0]         w_press_row;
    logic [3:0]         w_code;

    always_comb begin
        row_meta_d  = row;
        row_sync_d  = row_meta_q;
        div_d       = div_q;
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        deb_d       = deb_q;
        key_value_d = key_value_q;
        entry_d     = entry_q;
        count_d     = count_q;
        out_d       = out_q;
        enter_d     = 1'b0;
        w_press     = 1'b0;

        w_tick    = (div_q == c_div_last);
        div_d     = w_tick ? '0 : div_q + c_div_w'(1);
        w_row_low = ~row_sync_q;

        // Lowest-index low row wins when several rows are low.
        if (w_row_low[0])      w_lowest = 2'd0;
        else if (w_row_low[1]) w_lowest = 2'd1;
        else if (w_row_low[2]) w_lowest = 2'd2;
        else                   w_lowest = 2'd3;

        if (w_tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (|w_row_low) begin
                        row_idx_d = w_lowest;
                        deb_d     = c_deb_one;
                        // A single-tick debounce accepts on the detecting tick.
                        if (DEBOUNCE == 1) begin
                            state_d = ST_HELD;
                            w_press = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_row_low[row_idx_q]) begin
                        deb_d = deb_q + c_deb_one;
                        if ((deb_q + c_deb_one) == c_deb) begin
                            state_d = ST_HELD;
                            w_press = 1'b1;
                        end
                    end else begin
                        // Bounce: resume scanning at the same column.
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (!w_row_low[row_idx_q]) begin
                        deb_d = c_deb_one;
                        if (DEBOUNCE == 1) begin
                            state_d   = ST_SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                default: begin // ST_RELEASE
                    if (!w_row_low[row_idx_q]) begin
                        deb_d = deb_q + c_deb_one;
                        if ((deb_q + c_deb_one) == c_deb) begin
                            state_d   = ST_SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
            endcase
        end

        // The row for a press taken straight out of SCAN has not been latched yet.
        w_press_row = (state_q == ST_SCAN) ? w_lowest : row_idx_q;
        w_code      = key_code(w_press_row, col_idx_q);

        if (w_press) begin
            key_value_d = w_code;
            if (w_code == 4'd15) begin
                out_d   = entry_q;
                enter_d = 1'b1;
                entry_d = '0;
                count_d = '0;
            end else if (w_code == 4'd14) begin
                if (count_q != '0) begin
                    entry_d = entry_q >> 4;
                    count_d = count_q - c_cnt_one;
                end
            end else if ((w_code <= 4'd9) || hex_mode) begin
                if (count_q < c_digits) begin
                    entry_d = (entry_q << 4) | c_dw'(w_code);
                    count_d = count_q + c_cnt_one;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= '0;
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            deb_q       <= '0;
            key_value_q <= 4'd0;
            entry_q     <= '0;
            count_q     <= '0;
            out_q       <= '0;
            enter_q     <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            div_q       <= div_d;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            deb_q       <= deb_d;
            key_value_q <= key_value_d;
            entry_q     <= entry_d;
            count_q     <= count_d;
            out_q       <= out_d;
            enter_q     <= enter_d;
        end
    end

    // key_value shows the new code during the key_valid pulse itself.
    assign key_valid = w_press;
    assign key_value = w_press ? w_code : key_value_q;
    assign col       = ~(4'b0001 << col_idx_q);
    assign entry     = entry_q;
    assign count     = count_q;
    assign full      = (count_q == c_digits);
    assign out       = out_q;
    assign enter     = enter_q;

endmodule
`default_nettype wire
